// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: widths, opcodes, FSM states and small datapath helpers.
package lc3_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int REG_COUNT  = 8;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  // Sign-extend the low 'bits' bits of v to a full word.
  function automatic word_t sext(input word_t v, input int unsigned bits);
    logic signed [WORD_WIDTH-1:0] t;
    t = v << (WORD_WIDTH - bits);
    return t >>> (WORD_WIDTH - bits);
  endfunction

  function automatic logic [2:0] nzp(input word_t v);
    return v[WORD_WIDTH-1] ? 3'b100 : ((v == '0) ? 3'b010 : 3'b001);
  endfunction
endpackage

// File: rtl/lc3_mem_if.sv
// Unified memory port: single request/ready transaction, core is master.
interface lc3_mem_if;
  import lc3_pkg::*;
  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/lc3_regfile.sv
// 8x16 register file: two async read ports, one sync write port, async clear.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] wrAddr,
  input  word_t      wrData,
  input  logic [2:0] rdAddrA,
  input  logic [2:0] rdAddrB,
  output word_t      rdDataA,
  output word_t      rdDataB
);
  word_t regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];
endmodule

// File: rtl/lc3_multicycle_core.sv
// Multi-cycle LC-3 core: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port.
module lc3_multicycle_core
  import lc3_pkg::*;
#(
  parameter word_t START_ADDR = 16'h3000,
  parameter bit    EXT_ISA    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  lc3_mem_if.master    mem,
  output word_t        pc,
  output logic [2:0]   cc,
  output logic         halted
);
  state_t     state;
  word_t      ir, aReg, bReg, aluOut, mdr;
  word_t      rdDataA, rdDataB, wbData, opB, off9, off6;
  logic [3:0] op;
  logic [2:0] rdAddrB;
  logic       isLoad, isStore, legal;

  assign op      = ir[15:12];
  assign isLoad  = (op == OP_LD) || (op == OP_LDR);
  assign isStore = (op == OP_ST) || (op == OP_STR);
  assign rdAddrB = isStore ? ir[11:9] : ir[2:0];
  assign wbData  = isLoad ? mdr : aluOut;
  assign off9    = sext(word_t'(ir[8:0]), 9);
  assign off6    = sext(word_t'(ir[5:0]), 6);
  assign opB     = ir[5] ? sext(word_t'(ir[4:0]), 5) : bReg;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_ST, OP_JMP: legal = 1'b1;
      OP_BR, OP_LEA, OP_LDR, OP_STR:                legal = EXT_ISA;
      default:                                      legal = 1'b0;
    endcase
  end

  // Request is held low during reset so an in-flight store is dropped.
  assign mem.mem_req   = rst && ((state == S_FETCH) || (state == S_MEM));
  assign mem.mem_we    = (state == S_MEM) && isStore;
  assign mem.mem_addr  = (state == S_MEM) ? aluOut : pc;
  assign mem.mem_wdata = bReg;

  lc3_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (state == S_WB),
    .wrAddr  (ir[11:9]),
    .wrData  (wbData),
    .rdAddrA (ir[8:6]),
    .rdAddrB (rdAddrB),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      pc     <= START_ADDR;
      ir     <= '0;
      aReg   <= '0;
      bReg   <= '0;
      aluOut <= '0;
      mdr    <= '0;
      cc     <= 3'b010;
      halted <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem.mem_ready) begin
          ir    <= mem.mem_rdata;
          pc    <= pc + 16'd1;
          state <= S_DECODE;
        end
        S_DECODE: if (!legal) begin
          state  <= S_HALT;
          halted <= 1'b1;
        end else begin
          aReg  <= rdDataA;
          bReg  <= rdDataB;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WB;
          case (op)
            OP_ADD: aluOut <= aReg + opB;
            OP_AND: aluOut <= aReg & opB;
            OP_NOT: aluOut <= ~aReg;
            OP_LEA: aluOut <= pc + off9;
            OP_LD, OP_ST: begin
              aluOut <= pc + off9;
              state  <= S_MEM;
            end
            OP_LDR, OP_STR: begin
              aluOut <= aReg + off6;
              state  <= S_MEM;
            end
            OP_JMP: begin
              pc    <= aReg;
              state <= S_FETCH;
            end
            OP_BR: begin
              if ((ir[11:9] & cc) != 3'b000) pc <= pc + off9;
              state <= S_FETCH;
            end
            default: state <= S_HALT;
          endcase
        end
        S_MEM: if (mem.mem_ready) begin
          if (isLoad) begin
            mdr   <= mem.mem_rdata;
            state <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB: begin
          // LEA computes an address, so it leaves the flags alone.
          if (op != OP_LEA) cc <= nzp(wbData);
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: doc/lc3_multicycle_core.md
# lc3_multicycle_core

Multi-cycle LC-3 processor core with a single shared memory port under a request/ready handshake. Sequences each instruction through a fetch/decode/execute/memory/writeback state machine. Adds NZP condition codes, conditional branch, LEA, and base+offset loads and stores. Sits between the testbench or SoC top and one unified memory model, which may insert wait states.

## Interface
- START_ADDR, 16'h3000, PC value after reset
- EXT_ISA, 1, 1 enables BR/LEA/LDR/STR; 0 treats those opcodes as illegal (ADD/AND/NOT/LD/ST/JMP only)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, valid while mem_req
- mem_addr  out  16  transaction address
- mem_wdata  out  16  store data
- mem_rdata  in  16  read data, sampled on the edge where mem_ready=1
- mem_ready  in  1  transaction completes at this clock edge; may be combinational from mem_req
- pc  out  16  current PC (debug)
- cc  out  3  {N,Z,P} condition codes
- halted  out  1  sticky; set on illegal opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stay until mem_ready; then IR<=mem_rdata, PC<=PC+1, go to DECODE.
- DECODE: latch A<=R[IR[8:6]], B<=R[IR[2:0]] (ST/STR: B<=R[IR[11:9]]). Illegal opcode -> HALT.
- EXEC:
  - ADD/AND: ALUOUT <= A op (IR[5] ? sext(IR[4:0]) : B)
  - NOT: ALUOUT <= ~A
  - LD/ST/LEA: ALUOUT <= PC+sext(IR[8:0])
  - LDR/STR: ALUOUT <= A+sext(IR[5:0])
  - JMP: PC<=A -> FETCH
  - BR: if (IR[11:9] & cc)!=0 then PC<=PC+sext(IR[8:0]); -> FETCH
  - Memory ops -> MEM; others -> WB.
- MEM: mem_req=1, mem_addr=ALUOUT, mem_we=1 for ST/STR, mem_wdata=B. Hold until mem_ready. Stores -> FETCH; loads latch MDR<=mem_rdata -> WB.
- WB: R[IR[11:9]] <= (load ? MDR : ALUOUT).
  - cc updated from the written value for ADD/AND/NOT/LD/LDR: N = bit15; Z = value==0; P = otherwise.
  - LEA writes the register but leaves cc unchanged.
  - -> FETCH.
- HALT: absorbing. mem_req=0. Exit only via rst.
- Instruction 16'h0000 (BR, nzp=000) is a NOP.

## Timing
- Reset values: PC=START_ADDR, state=FETCH, IR=0, cc=3'b010, halted=0, all 8 registers=0.
- mem_req is gated low while rst is asserted.
- Zero-wait memory (mem_ready tied 1), cycles per instruction:
  - BR, JMP: 3
  - ADD, AND, NOT, LEA, ST, STR: 4
  - LD, LDR: 5
- Each wait cycle adds 1.
- While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata hold stable. mem_req never drops before completion.
- mem_req=0 in DECODE, EXEC, WB and HALT.
- At most one transaction is outstanding.
- Arithmetic is modulo 2^16. PC+1 wraps 16'hFFFF -> 16'h0000. Branch and offset targets wrap likewise.
- Register reads in DECODE see writes from the previous instruction's WB, because WB precedes the next FETCH.
- rst asserted mid-transaction: immediate return to reset values. A pending store is not performed.
- halted rises the cycle after DECODE of an illegal opcode.

## Structure
- Shared package lc3_pkg:
  - opcode constants
  - state enum
  - WORD_WIDTH=16, REG_COUNT=8
  - sign-extend function
- One sub-module, lc3_regfile: 8x16, two async read ports, one sync write port, async active-low reset to 0.
- ALU, FSM and NZP logic live inline in the core.

## Test plan
- ADD R1,R0,#5 then ADD R2,R1,#-6 at 0x3000: R1=5, cc=001; then R2=16'hFFFF, cc=100; PC=0x3002 after 8 cycles.
- ST R1 to 0x3010 then LD R3 from it, with 2 wait states per memory access: mem_addr/mem_wdata stable during waits; R3=5; cc=001; cycle counts include the waits.
- LDR/STR with base R4=0xFFFE and offset +3: address wraps to 0x0001.
- BRz taken after AND R0,R0,#0: PC=target. BRn not taken: PC=PC+1. Word 0x0000 behaves as a NOP in 3 cycles.
- JMP R5=0x4000: next FETCH has mem_addr=0x4000. With EXT_ISA=0, LEA raises halted, then mem_req stays 0.
- rst pulsed during a stalled MEM store: no write occurs, PC=0x3000, cc=010.
